// File: rtl/icache_responder.sv
// -----------------------------------------------------------------------------
// icache_responder
//
// Read-only, direct-mapped instruction cache serving the fetch stage.
// A read that hits returns its word in the same cycle. A read that misses
// stalls the fetch stage while a 4-word line is refilled from instruction
// memory over a request/ready bus. Writes from the fetch side are ignored.
//
// Optional build macro: ICACHE_PERF_CNT_EN
//   When defined, adds saturating hit_cnt / miss_cnt outputs.
//
// Ports:
//   clk         rising-edge clock
//   proc_reset  asynchronous active-high reset
//   proc_read   fetch read request
//   proc_write  fetch write request (ignored)
//   proc_addr   30-bit word address {tag, index, 2-bit word offset}
//   proc_wdata  fetch write data (ignored)
//   proc_rdata  fetched word, 0 when nothing is being served
//   proc_stall  high while the current read cannot be served
//   mem_read    line fill request (registered)
//   mem_write   tied 0
//   mem_addr    28-bit line address of the outstanding/last fill (registered)
//   mem_wdata   tied 0
//   mem_rdata   fill line, word0 in [31:0] .. word3 in [127:96]
//   mem_ready   one-cycle pulse, mem_rdata valid in that cycle
//   hit_cnt     (ICACHE_PERF_CNT_EN) served read hits, saturating
//   miss_cnt    (ICACHE_PERF_CNT_EN) started refills, saturating
// -----------------------------------------------------------------------------
module icache_responder #(
  parameter int NUM_SETS = 8,
  parameter int INDEX_W  = 3,
  parameter int TAG_W    = 25
) (
  input  logic          clk,
  input  logic          proc_reset,
  input  logic          proc_read,
  input  logic          proc_write,
  input  logic [29:0]   proc_addr,
  input  logic [31:0]   proc_wdata,
  output logic [31:0]   proc_rdata,
  output logic          proc_stall,
  output logic          mem_read,
  output logic          mem_write,
  output logic [27:0]   mem_addr,
  output logic [127:0]  mem_wdata,
  input  logic [127:0]  mem_rdata,
  input  logic          mem_ready
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt,
  output logic [31:0]   miss_cnt
`endif
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ALLOCATE = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;

  // Storage: only valid bits are reset; tags and data are qualified by valid.
  logic [NUM_SETS-1:0]  valid_r;
  logic [TAG_W-1:0]     tag_arr_r  [NUM_SETS];
  logic [127:0]         data_arr_r [NUM_SETS];

  // Line address of the outstanding miss; doubles as the mem_addr register.
  logic [27:0]          miss_addr_r;
  logic                 mem_read_r;

  logic [1:0]           offset_s;
  logic [INDEX_W-1:0]   index_s;
  logic [TAG_W-1:0]     tag_s;
  logic [INDEX_W-1:0]   miss_index_s;
  logic                 hit_s;
  logic [31:0]          word_s;
  logic                 fill_s;
  logic                 start_miss_s;
  logic                 unused_ok_s;

  // Pick one 32-bit word out of a 128-bit line.
  function automatic logic [31:0] sel_word(input logic [127:0] line, input logic [1:0] off);
    logic [31:0] w;
    case (off)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      2'd3:    w = line[127:96];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign offset_s     = proc_addr[1:0];
  assign index_s      = proc_addr[INDEX_W+1:2];
  assign tag_s        = proc_addr[29:INDEX_W+2];
  assign miss_index_s = miss_addr_r[INDEX_W-1:0];

  assign hit_s  = valid_r[index_s] & (tag_arr_r[index_s] == tag_s);
  assign word_s = sel_word(data_arr_r[index_s], offset_s);

  // A fill only lands while a miss is outstanding; mem_ready in IDLE is dropped.
  assign fill_s       = (state_r == ALLOCATE) & mem_ready;
  assign start_miss_s = (state_r == IDLE) & proc_read & ~hit_s;

  assign mem_read  = mem_read_r;
  assign mem_addr  = miss_addr_r;
  assign mem_write = 1'b0;
  assign mem_wdata = 128'h0;

  // Write-side inputs have no function in a read-only cache.
  assign unused_ok_s = ^{proc_write, proc_wdata};

  // Next-state and fetch-side outputs; hits are answered combinationally.
  always_comb begin
    state_nxt_s = state_r;
    proc_stall  = 1'b0;
    proc_rdata  = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (proc_read) begin
          if (hit_s) begin
            proc_rdata = word_s;
          end else begin
            proc_stall  = 1'b1;
            state_nxt_s = ALLOCATE;
          end
        end else begin
          proc_stall = 1'b0;
        end
      end
      ALLOCATE: begin
        // Stall regardless of proc_read: the fill is never aborted.
        proc_stall = 1'b1;
        if (mem_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ALLOCATE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Miss address latch and registered memory request.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      miss_addr_r <= 28'h000_0000;
      mem_read_r  <= 1'b0;
    end else begin
      if (start_miss_s) begin
        miss_addr_r <= proc_addr[29:2];
      end
      mem_read_r <= (state_nxt_s == ALLOCATE);
    end
  end

  // Valid bits: cleared by reset, set when a fill lands.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      valid_r <= {NUM_SETS{1'b0}};
    end else if (fill_s) begin
      valid_r[miss_index_s] <= 1'b1;
    end
  end

  // Tag and data arrays; a fill simply overwrites whatever occupied the set.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      tag_arr_r[miss_index_s]  <= miss_addr_r[27:INDEX_W];
      data_arr_r[miss_index_s] <= mem_rdata;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_r;
  logic [31:0] miss_cnt_r;

  assign hit_cnt  = hit_cnt_r;
  assign miss_cnt = miss_cnt_r;

  // Saturating hit counter: one count per IDLE cycle that serves a hit.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt_r <= 32'h0000_0000;
    end else if ((state_r == IDLE) && proc_read && hit_s && !(&hit_cnt_r)) begin
      hit_cnt_r <= hit_cnt_r + 32'd1;
    end
  end

  // Saturating miss counter: one count per IDLE to ALLOCATE transition.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      miss_cnt_r <= 32'h0000_0000;
    end else if (start_miss_s && !(&miss_cnt_r)) begin
      miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_responder.sv
module tb_icache_responder;

  logic          clk;
  logic          proc_reset;
  logic          proc_read;
  logic          proc_write;
  logic [29:0]   proc_addr;
  logic [31:0]   proc_wdata;
  logic [31:0]   proc_rdata;
  logic          proc_stall;
  logic          mem_read;
  logic          mem_write;
  logic [27:0]   mem_addr;
  logic [127:0]  mem_wdata;
  logic [127:0]  mem_rdata;
  logic          mem_ready;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected fetched words and expected fill addresses.
  logic [31:0] rd_q[$];
  logic [27:0] ma_q[$];

  localparam logic [127:0] L0 = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
  localparam logic [127:0] L1 = {32'h00000014, 32'h00000013, 32'h00000012, 32'h00000011};
  localparam logic [127:0] L2 = {32'h00000024, 32'h00000023, 32'h00000022, 32'h00000021};
  localparam logic [127:0] L3 = {32'h00000034, 32'h00000033, 32'h00000032, 32'h00000031};

  icache_responder dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One fetch: hit or miss (with a 3-cycle memory refill), then check the word.
  task automatic fetch(input logic [29:0] addr, input logic exp_hit,
                       input logic [127:0] line, input logic [31:0] exp_word);
    int n;
    logic [27:0] ema;
    logic [31:0] ew;
    @(negedge clk);
    proc_read  = 1'b1;
    proc_write = 1'b0;
    proc_addr  = addr;
    rd_q.push_back(exp_word);
    #1;
    checks++;
    if (proc_stall !== !exp_hit) begin
      errors++;
      $display("FAIL hit_detect addr=%h: stall=%b expected %b", addr, proc_stall, !exp_hit);
    end
    if (!exp_hit) begin
      ma_q.push_back(addr[29:2]);
      @(negedge clk); #1;
      checks++;
      if (mem_read !== 1'b1) begin
        errors++;
        $display("FAIL mem_read_req addr=%h: got %b expected 1", addr, mem_read);
      end
      ema = ma_q.pop_front();
      checks++;
      if (mem_addr !== ema) begin
        errors++;
        $display("FAIL mem_addr addr=%h: got %h expected %h", addr, mem_addr, ema);
      end
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b1;
      mem_rdata = line;
      #1;
      checks++;
      if (proc_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_during_fill addr=%h: got %b expected 1", addr, proc_stall);
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 128'h0;
      #1;
    end
    n = 0;
    while (proc_stall !== 1'b0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (proc_stall !== 1'b0 || n != 0) begin
      errors++;
      $display("FAIL serve_cycle addr=%h: stall=%b extra_cycles=%0d expected stall 0 after 0", addr, proc_stall, n);
    end
    ew = rd_q.pop_front();
    checks++;
    if (proc_rdata !== ew) begin
      errors++;
      $display("FAIL rdata addr=%h: got %h expected %h", addr, proc_rdata, ew);
    end
    checks++;
    if (mem_read !== 1'b0) begin
      errors++;
      $display("FAIL mem_read_idle addr=%h: got %b expected 0", addr, mem_read);
    end
  endtask

  task automatic test_reset();
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'h0;
    proc_wdata = 32'h0;
    mem_rdata  = 128'h0;
    mem_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_proc: stall=%b rdata=%h expected 0/0", proc_stall, proc_rdata);
    end
    checks++;
    if (mem_read !== 1'b0 || mem_addr !== 28'h0 || mem_write !== 1'b0 || mem_wdata !== 128'h0) begin
      errors++;
      $display("FAIL reset_mem: read=%b addr=%h write=%b expected 0/0/0", mem_read, mem_addr, mem_write);
    end
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  task automatic test_cold_miss();
    fetch(30'h0000001, 1'b0, L0, 32'h0000000B);
  endtask

  task automatic test_line_hit();
    fetch(30'h0000003, 1'b1, L0, 32'h0000000D);
    fetch(30'h0000000, 1'b1, L0, 32'h0000000A);
  endtask

  task automatic test_write_and_idle_ready();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b1;
    proc_wdata = 32'hFFFF_FFFF;
    proc_addr  = 30'h0000002;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL write_ignored: stall=%b rdata=%h mem_read=%b expected 0/0/0", proc_stall, proc_rdata, mem_read);
    end
    // Stray mem_ready while idle must not touch the arrays.
    mem_ready = 1'b1;
    mem_rdata = {4{32'h5555_5555}};
    @(negedge clk);
    mem_ready  = 1'b0;
    mem_rdata  = 128'h0;
    proc_write = 1'b0;
    fetch(30'h0000002, 1'b1, L0, 32'h0000000C);
  endtask

  task automatic test_conflict();
    fetch(30'h0000020, 1'b0, L1, 32'h00000011);
    fetch(30'h0000000, 1'b0, L0, 32'h0000000A);
  endtask

  task automatic test_redirect();
    logic [27:0] ema;
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h0000040;
    ma_q.push_back(28'h0000010);
    #1;
    checks++;
    if (proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL redirect_miss: stall=%b expected 1", proc_stall);
    end
    @(negedge clk);
    proc_addr = 30'h0000004;
    #1;
    ema = ma_q.pop_front();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== ema) begin
      errors++;
      $display("FAIL redirect_req: read=%b addr=%h expected 1/%h", mem_read, mem_addr, ema);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = L3;
    #1;
    checks++;
    if (mem_addr !== 28'h0000010 || proc_stall !== 1'b1) begin
      errors++;
      $display("FAIL redirect_fill: addr=%h stall=%b expected 0000010/1", mem_addr, proc_stall);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    ma_q.push_back(28'h0000001);
    #1;
    checks++;
    if (proc_stall !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL redirect_remiss: stall=%b mem_read=%b expected 1/0", proc_stall, mem_read);
    end
    @(negedge clk); #1;
    ema = ma_q.pop_front();
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== ema) begin
      errors++;
      $display("FAIL redirect_req2: read=%b addr=%h expected 1/%h", mem_read, mem_addr, ema);
    end
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = L2;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    #1;
    checks++;
    if (proc_stall !== 1'b0 || proc_rdata !== 32'h00000021) begin
      errors++;
      $display("FAIL redirect_serve: stall=%b rdata=%h expected 0/00000021", proc_stall, proc_rdata);
    end
    fetch(30'h0000040, 1'b1, L3, 32'h00000031);
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    proc_read = 1'b1;
    proc_addr = 30'h0000008;
    @(negedge clk); #1;
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_req: read=%b expected 1", mem_read);
    end
    @(negedge clk);
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_addr !== 28'h0 || proc_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: read=%b addr=%h stall=%b expected 0/0/0", mem_read, mem_addr, proc_stall);
    end
    @(negedge clk);
    proc_reset = 1'b0;
    mem_ready  = 1'b1;
    mem_rdata  = L1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 128'h0;
    fetch(30'h0000008, 1'b0, L2, 32'h00000021);
    fetch(30'h0000040, 1'b0, L3, 32'h00000031);
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf_counters();
    @(negedge clk);
    proc_read  = 1'b0;
    proc_reset = 1'b1;
    #1;
    checks++;
    if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt);
    end
    @(negedge clk);
    proc_reset = 1'b0;
    fetch(30'h0000001, 1'b0, L0, 32'h0000000B);
    fetch(30'h0000003, 1'b1, L0, 32'h0000000D);
    @(negedge clk);
    proc_read = 1'b0;
    #1;
    checks++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts: hit=%0d miss=%0d expected 2/1", hit_cnt, miss_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      proc_write = 1'b1;
      proc_addr  = 30'h0000100 + 30'(i);
      @(negedge clk);
      proc_write = 1'b0;
    end
    #1;
    checks++;
    if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      errors++;
      $display("FAIL perf_write: hit=%0d miss=%0d expected 2/1", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_line_hit();
    test_write_and_idle_ready();
    test_conflict();
    test_redirect();
    test_reset_mid_miss();
`ifdef ICACHE_PERF_CNT_EN
    test_perf_counters();
`endif
    @(negedge clk);
    proc_read = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Read-only, direct-mapped instruction cache; the responder side of the fetch-stage ICACHE interface.
- Serves fetch word reads on hit in the same cycle. On miss, stalls the fetch stage and refills a 4-word line from instruction memory over a request/ready bus.
- Sits between the fetch stage and the instruction memory model/arbiter.

Parameters:
- NUM_SETS, 8, number of lines; power of two, minimum 2.
- INDEX_W, 3, log2(NUM_SETS).
- TAG_W, 25, 28-INDEX_W (word address 30b = tag | index | 2b word offset).

Ports:
- clk  in  1  clock, rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- proc_read  in  1  fetch read request (ICACHE_ren).
- proc_write  in  1  fetch write request (ICACHE_wen); always ignored.
- proc_addr  in  30  word address (ICACHE_addr).
- proc_wdata  in  32  ignored.
- proc_rdata  out  32  fetched word (ICACHE_rdata).
- proc_stall  out  1  high while the request cannot be served (ICACHE_stall).
- mem_read  out  1  line fill request.
- mem_write  out  1  tied 0.
- mem_addr  out  28  line address = word address [29:2].
- mem_wdata  out  128  tied 0.
- mem_rdata  in  128  fill data; word0 in [31:0], word3 in [127:96].
- mem_ready  in  1  one-cycle pulse; mem_rdata valid in that cycle.

Behaviour:
- Storage: per set, valid bit (1), tag (TAG_W), data (128). Only valid bits and FSM/miss registers are reset.
- Address decode: offset = proc_addr[1:0]; index = proc_addr[INDEX_W+1:2]; tag = proc_addr[29:INDEX_W+2].
- hit = valid[index] & (tag_arr[index] == tag), computed combinationally.
- FSM has two states, IDLE and ALLOCATE. Reset state is IDLE.
- IDLE, proc_read & hit:
  - proc_stall=0 and proc_rdata = selected word, both in the same cycle (zero-latency hit).
- IDLE, proc_read & !hit:
  - proc_stall=1 combinationally.
  - Latch miss_addr = proc_addr[29:2] and go to ALLOCATE.
- IDLE, !proc_read: proc_stall=0, proc_rdata=0, no state change.
- ALLOCATE:
  - mem_read=1 and mem_addr=miss_addr, both driven from registers; proc_stall=1 regardless of proc_read.
  - On mem_ready=1: write mem_rdata into the line at miss_addr index, set valid, write tag, go to IDLE.
  - The next IDLE cycle re-compares the current proc_addr.
- Miss penalty = memory latency + 1 cycle.
- mem_read is 0 in IDLE; mem_addr holds its last value when idle. Reset value 0.
- Redirect during a miss (proc_addr changes or proc_read drops in ALLOCATE): the fill always completes to the latched miss_addr and the memory transaction is never aborted. The new address is compared in IDLE afterwards and may miss again.
- mem_ready while in IDLE: ignored, no array update.
- proc_write=1: no effect, no stall, arrays unchanged.
- Conflict: a fill to an occupied index overwrites that line; no write-back is needed (read-only cache).
- Reset asserted mid-miss:
  - State returns to IDLE and all valid bits clear immediately (asynchronous).
  - mem_read drops to 0; any pending mem_ready is ignored.
- Reset values: proc_stall=0 (when proc_read=0), proc_rdata=0, mem_read=0, mem_addr=0.

Optional Feature:
- Macro: ICACHE_PERF_CNT_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments once per IDLE cycle with proc_read & hit.
  - miss_cnt increments once per IDLE→ALLOCATE transition.
  - Both clear on proc_reset and saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, proc_read=1, proc_addr=0x00000001.
  - Response: proc_stall=1; next cycle mem_read=1, mem_addr=0. Memory returns mem_ready after 3 cycles with mem_rdata={32'hD,32'hC,32'hB,32'hA}. The cycle after that, proc_stall=0 and proc_rdata=32'hB.
- Line hit:
  - Stimulus: following the cold miss, proc_addr=0x00000003.
  - Response: same-cycle proc_stall=0, proc_rdata=32'hD, mem_read stays 0.
- Conflict eviction:
  - Stimulus: with line 0 valid, read proc_addr=0x00000020 (same index 0, different tag).
  - Response: miss with mem_addr=0x0000008. After refill, reading proc_addr=0x00000000 misses again.
- Redirect in ALLOCATE:
  - Stimulus: miss on 0x00000040; during ALLOCATE switch proc_addr to 0x00000004.
  - Response: fill completes with mem_addr=0x10; next IDLE cycle misses on 0x4 with mem_addr=0x1.
- Reset mid-miss:
  - Stimulus: assert proc_reset during ALLOCATE.
  - Response: mem_read=0 immediately; a subsequent mem_ready pulse is ignored; reading the same address afterwards misses.
- Perf counters (ICACHE_PERF_CNT_EN defined):
  - Stimulus: the Cold miss and Line hit scenarios above.
  - Response: hit_cnt=2 (post-refill hit on 0x1 + hit on 0x3), miss_cnt=1; proc_write pulses change neither counter.
